// File: rtl/button_press_classifier_if.sv
// Button classifier signal bundle: debounced level in, classification pulses and press count out.
// The master drives the button level; the classifier connects through the slave modport.
interface button_press_classifier_if;
   logic       i_Debounced;
   logic       o_Short_Press;
   logic       o_Long_Press;
   logic       o_Double_Press;
   logic [7:0] o_Press_Count;

   modport master (
      output i_Debounced,
      input  o_Short_Press,
      input  o_Long_Press,
      input  o_Double_Press,
      input  o_Press_Count
   );

   modport slave (
      input  i_Debounced,
      output o_Short_Press,
      output o_Long_Press,
      output o_Double_Press,
      output o_Press_Count
   );
endinterface

// File: rtl/button_press_classifier.sv
// Classifies each press sequence of a debounced button as short, long or double,
// and keeps a wrapping 8-bit count of press onsets.
module button_press_classifier #(
   parameter int LONG_LIMIT   = 50_000_000,
   parameter int DOUBLE_LIMIT = 12_500_000
) (
   input  logic                      i_Clk,
   input  logic                      i_Rst_L,
   button_press_classifier_if.slave  bus
);

   localparam int MAX_LIMIT = (LONG_LIMIT > DOUBLE_LIMIT) ? LONG_LIMIT : DOUBLE_LIMIT;
   localparam int CNT_W     = $clog2(MAX_LIMIT);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_LIMIT - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_LIMIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_GAP,
      SECOND_HELD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             short_q;
   logic             long_q;
   logic             double_q;
   logic [7:0]       press_count;

   // One counter is shared: it times the hold in PRESSED and the release gap in WAIT_GAP.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= IDLE;
         count       <= '0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         double_q    <= 1'b0;
         press_count <= 8'd0;
      end else begin
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_Debounced) begin
                  state       <= PRESSED;
                  count       <= '0;
                  press_count <= press_count + 8'd1;
               end
            end
            PRESSED: begin
               if (bus.i_Debounced) begin
                  if (count == LONG_LAST) begin
                     long_q <= 1'b1;
                     state  <= LONG_HELD;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end else begin
                  state <= WAIT_GAP;
                  count <= '0;
               end
            end
            LONG_HELD: begin
               if (!bus.i_Debounced) begin
                  state <= IDLE;
               end
            end
            // Timeout is checked first so a re-press on the last gap edge still yields a short press.
            WAIT_GAP: begin
               if (count == DOUBLE_LAST) begin
                  short_q <= 1'b1;
                  state   <= IDLE;
               end else if (bus.i_Debounced) begin
                  double_q    <= 1'b1;
                  press_count <= press_count + 8'd1;
                  state       <= SECOND_HELD;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            SECOND_HELD: begin
               if (!bus.i_Debounced) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_Short_Press  = short_q;
   assign bus.o_Long_Press   = long_q;
   assign bus.o_Double_Press = double_q;
   assign bus.o_Press_Count  = press_count;

endmodule
